sram512_ctrl: RTL

Host-side controller for the 512x8 GF180 SRAM macro wrapper. It turns a valid/ready request port and a valid/ready read-response port into the macro's active-low pin protocol: CEN, GWEN, per-bit WEN, A, D, and Q. It holds at most one read outstanding and buffers the returned byte. It can also sweep the whole array to zero, either after reset or on command, so the AS2650 sees deterministic memory contents.

---
 rtl/sram512_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/sram512_ctrl.sv
// sram512_ctrl: host-side controller for the 512x8 GF180 SRAM macro.
// Converts a valid/ready request port and a valid/ready read-response port
// into the macro's active-low pin protocol, with a zero-fill sweep that runs
// after reset (optional) or on command.
module sram512_ctrl #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [8:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [7:0] req_wmask,
    input  logic       clr_req,
    output logic       busy,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       CEN,
    output logic       GWEN,
    output logic [7:0] WEN,
    output logic [8:0] A,
    output logic [7:0] D,
    input  logic [7:0] Q
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CLEAR = 2'd1,
        IDLE  = 2'd2,
        RDCAP = 2'd3
    } state_t;

    state_t     state;
    logic [8:0] sweep_addr;
    logic       clr_go;
    logic       accept;

    // A pending response blocks new requests unless it is consumed this cycle;
    // a clear command wins over a simultaneous request.
    assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
    assign clr_go    = req_ready && clr_req;
    assign accept    = req_ready && req_valid && !clr_req;
    assign busy      = (state == CLEAR);

    // Control state machine and zero-fill sweep counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= WAIT;
            sweep_addr <= 9'd0;
        end else begin
            case (state)
                WAIT: begin
                    state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
                    sweep_addr <= 9'd0;
                end
                CLEAR: begin
                    sweep_addr <= sweep_addr + 9'd1;
                    if (sweep_addr == 9'd511) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr_go) begin
                        state      <= CLEAR;
                        sweep_addr <= 9'd0;
                    end else if (accept && !req_we) begin
                        state <= RDCAP;
                    end
                end
                RDCAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

    // Read response buffer: capture Q in RDCAP, hold until the host consumes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else if (state == RDCAP) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= Q;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Macro pin mux: the macro samples these on the edge that completes the handshake.
    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = 8'hFF;
        A    = 9'd0;
        D    = 8'h00;
        if (state == CLEAR) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = 8'h00;
            A    = sweep_addr;
        end else if (accept) begin
            CEN  = 1'b0;
            GWEN = !req_we;
            WEN  = req_we ? ~req_wmask : 8'hFF;
            A    = req_addr;
            D    = req_wdata;
        end
    end

endmodule
